program_loader: RTL and testbench

- Writer side of the instruction-memory interface that the pipeline's fetch stage reads.
- Accepts a byte stream over a valid/ready handshake (host/UART side) and assembles big-endian 32-bit instruction words.
- Writes the words into instruction memory through a dedicated write port.
- Holds the CPU in reset until a complete image has been loaded.

---
 rtl/loader_pkg.sv | 34 +++
 rtl/program_loader_if.sv | 24 ++
 rtl/word_assembler.sv | 46 ++++
 rtl/program_loader.sv | 126 ++++++++++++
 tb/tb_program_loader.sv | 270 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/loader_pkg.sv
// Shared types and constants for the program loader.
// PROGRAM_LOADER_CHECKSUM_EN adds a trailing XOR checksum byte (CHECK state).
package loader_pkg;

  localparam int BYTES_PER_WORD = 4;
  localparam int LEN_WIDTH      = 16;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEN_HI,
    S_LEN_LO,
    S_DATA,
    S_CHECK,
    S_FINISH,
    S_DONE,
    S_ERROR
  } state_t;

`ifdef PROGRAM_LOADER_CHECKSUM_EN
  localparam state_t S_AFTER_PAYLOAD = S_CHECK;
`else
  localparam state_t S_AFTER_PAYLOAD = S_FINISH;
`endif

  // States in which the byte stream is allowed to transfer.
  function automatic logic takes_bytes(input state_t s);
`ifdef PROGRAM_LOADER_CHECKSUM_EN
    return (s == S_LEN_HI) || (s == S_LEN_LO) || (s == S_DATA) || (s == S_CHECK);
`else
    return (s == S_LEN_HI) || (s == S_LEN_LO) || (s == S_DATA);
`endif
  endfunction

endpackage

// File: rtl/program_loader_if.sv
// Byte-stream input and instruction-memory write port of the program loader.
// master = host/stream side, slave = loader side.
interface program_loader_if #(
  parameter int ADDR_WIDTH = 8
);

  logic                  in_valid;
  logic [7:0]            in_data;
  logic                  out_ready;
  logic                  out_wr_en;
  logic [ADDR_WIDTH-1:0] out_wr_addr;
  logic [31:0]           out_wr_data;

  modport master (
    output in_valid, in_data,
    input  out_ready, out_wr_en, out_wr_addr, out_wr_data
  );

  modport slave (
    input  in_valid, in_data,
    output out_ready, out_wr_en, out_wr_addr, out_wr_data
  );

endinterface

// File: rtl/word_assembler.sv
// Packs accepted bytes MSB-first into 32-bit words; word_vld_o pulses one cycle
// after the 4th byte, and the held word stays stable while the next one shifts in.
module word_assembler
  import loader_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        clr_i,
  input  logic        byte_vld_i,
  input  logic [7:0]  byte_dat_i,
  output logic        byte_last_o,
  output logic        word_vld_o,
  output logic [31:0] word_dat_o
);

  localparam int CW = $clog2(BYTES_PER_WORD);

  logic [CW-1:0] cnt_q;
  logic [23:0]   shift_q;
  logic [31:0]   word_q;
  logic          word_vld_q;

  assign byte_last_o = byte_vld_i && (cnt_q == CW'(BYTES_PER_WORD - 1));

  always_ff @(posedge clk) begin
    if (rst || clr_i) begin
      cnt_q      <= '0;
      shift_q    <= '0;
      word_q     <= '0;
      word_vld_q <= 1'b0;
    end else begin
      word_vld_q <= byte_last_o;
      if (byte_vld_i) begin
        shift_q <= {shift_q[15:0], byte_dat_i};
        cnt_q   <= cnt_q + CW'(1);
      end
      if (byte_last_o) begin
        word_q <= {shift_q, byte_dat_i};
      end
    end
  end

  assign word_vld_o = word_vld_q;
  assign word_dat_o = word_q;

endmodule

// File: rtl/program_loader.sv
// Loads a length-prefixed big-endian word image into instruction memory and holds
// the CPU in reset until it completes. PROGRAM_LOADER_CHECKSUM_EN adds a checksum byte.
module program_loader
  import loader_pkg::*;
#(
  parameter int ADDR_WIDTH = 8,
  parameter int BASE_ADDR  = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_start,
  program_loader_if.slave      bus,
  output logic                 out_cpu_hold,
  output logic                 out_busy,
  output logic                 out_done,
  output logic                 out_error,
  output logic [LEN_WIDTH-1:0] out_word_count
);

  localparam logic [LEN_WIDTH:0] DEPTH = (LEN_WIDTH + 1)'(1) << ADDR_WIDTH;

  state_t                state_q, state_d;
  logic                  ready_q, busy_q, done_q, error_q, hold_q;
  logic [LEN_WIDTH-1:0]  len_q, word_cnt_q, len_rx;
  logic [ADDR_WIDTH-1:0] wr_addr_q;
  logic                  byte_acc, data_acc, start_acc;
  logic                  byte_last, word_vld;
  logic [31:0]           word_dat;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
  logic [7:0]            csum_q;
`endif

  // ready_q is registered from the next state, so it always matches state_q.
  assign byte_acc  = bus.in_valid && ready_q;
  assign data_acc  = byte_acc && (state_q == S_DATA);
  assign start_acc = in_start && (state_q inside {S_IDLE, S_DONE, S_ERROR});
  assign len_rx    = {len_q[LEN_WIDTH-1 -: 8], bus.in_data};

  word_assembler u_asm (
    .clk         (clk),
    .rst         (rst),
    .clr_i       (start_acc),
    .byte_vld_i  (data_acc),
    .byte_dat_i  (bus.in_data),
    .byte_last_o (byte_last),
    .word_vld_o  (word_vld),
    .word_dat_o  (word_dat)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE, S_DONE, S_ERROR: if (in_start) state_d = S_LEN_HI;
      S_LEN_HI: if (byte_acc) state_d = S_LEN_LO;
      S_LEN_LO: begin
        if (byte_acc) begin
          if (len_rx == '0)                     state_d = S_AFTER_PAYLOAD;
          else if ({1'b0, len_rx} > DEPTH)      state_d = S_ERROR;
          else                                  state_d = S_DATA;
        end
      end
      S_DATA: begin
        if (byte_last && (word_cnt_q == len_q - LEN_WIDTH'(1))) state_d = S_AFTER_PAYLOAD;
      end
`ifdef PROGRAM_LOADER_CHECKSUM_EN
      S_CHECK: begin
        if (byte_acc) state_d = (bus.in_data == csum_q) ? S_DONE : S_ERROR;
      end
`endif
      S_FINISH: state_d = S_DONE;
      default:  state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      ready_q    <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      error_q    <= 1'b0;
      hold_q     <= 1'b1;
      len_q      <= '0;
      word_cnt_q <= '0;
      wr_addr_q  <= '0;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
      csum_q     <= '0;
`endif
    end else begin
      state_q <= state_d;
      ready_q <= takes_bytes(state_d);
      busy_q  <= state_d inside {S_LEN_HI, S_LEN_LO, S_DATA, S_CHECK, S_FINISH};
      done_q  <= (state_d == S_DONE);
      error_q <= (state_d == S_ERROR);
      hold_q  <= (state_d != S_DONE);

      if (start_acc) begin
        word_cnt_q <= '0;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
        csum_q     <= '0;
`endif
      end
      if (byte_acc && (state_q == S_LEN_HI)) len_q[LEN_WIDTH-1 -: 8] <= bus.in_data;
      if (byte_acc && (state_q == S_LEN_LO)) len_q[7:0] <= bus.in_data;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
      if (data_acc) csum_q <= csum_q ^ bus.in_data;
`endif
      // Address is latched with the last byte so it is valid for the whole pulse.
      if (byte_last) begin
        word_cnt_q <= word_cnt_q + LEN_WIDTH'(1);
        wr_addr_q  <= ADDR_WIDTH'(BASE_ADDR) + word_cnt_q[ADDR_WIDTH-1:0];
      end
    end
  end

  assign bus.out_ready   = ready_q;
  assign bus.out_wr_en   = word_vld;
  assign bus.out_wr_addr = wr_addr_q;
  assign bus.out_wr_data = word_dat;
  assign out_cpu_hold    = hold_q;
  assign out_busy        = busy_q;
  assign out_done        = done_q;
  assign out_error       = error_q;
  assign out_word_count  = word_cnt_q;

endmodule

// File: tb/tb_program_loader.sv
// Directed bench for program_loader: two instances (BASE_ADDR 0 and 254).
// Frames get a trailing checksum byte when PROGRAM_LOADER_CHECKSUM_EN is defined.
module tb_program_loader;

  typedef struct packed {
    logic [7:0]  a;
    logic [31:0] d;
    logic        h;
    int          c;
  } wr_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       vld[2];
  logic [7:0] dat[2];
  logic       st[2];
  int         total = 0;
  int         bad = 0;
  int         cyc = 0;
  int         done_cyc[2];
  logic       prev_done[2];
  wr_t        wq0[$];
  wr_t        wq1[$];

  logic        hold0, busy0, done0, err0, hold1, busy1, done1, err1;
  logic [15:0] wc0, wc1;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  program_loader_if #(.ADDR_WIDTH(8)) bus0 ();
  program_loader_if #(.ADDR_WIDTH(8)) bus1 ();

  assign bus0.in_valid = vld[0];
  assign bus0.in_data  = dat[0];
  assign bus1.in_valid = vld[1];
  assign bus1.in_data  = dat[1];

  program_loader #(.ADDR_WIDTH(8), .BASE_ADDR(0)) dut0 (
    .clk(clk), .rst(rst), .in_start(st[0]), .bus(bus0),
    .out_cpu_hold(hold0), .out_busy(busy0), .out_done(done0),
    .out_error(err0), .out_word_count(wc0)
  );

  program_loader #(.ADDR_WIDTH(8), .BASE_ADDR(254)) dut1 (
    .clk(clk), .rst(rst), .in_start(st[1]), .bus(bus1),
    .out_cpu_hold(hold1), .out_busy(busy1), .out_done(done1),
    .out_error(err1), .out_word_count(wc1)
  );

  always @(negedge clk) begin
    if (bus0.out_wr_en) wq0.push_back(wr_t'{bus0.out_wr_addr, bus0.out_wr_data, hold0, cyc});
    if (bus1.out_wr_en) wq1.push_back(wr_t'{bus1.out_wr_addr, bus1.out_wr_data, hold1, cyc});
    prev_done[0] <= done0;
    prev_done[1] <= done1;
    if (done0 && !prev_done[0]) done_cyc[0] <= cyc;
    if (done1 && !prev_done[1]) done_cyc[1] <= cyc;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic pulse_start(input int d);
    @(negedge clk); st[d] = 1'b1;
    @(negedge clk); st[d] = 1'b0;
  endtask

  // Presents one byte and holds it until the loader accepts it.
  task automatic drive(input int d, input logic [7:0] b, input bit gap);
    int  t;
    bit  ok;
    logic r;
    t = 0; ok = 0;
    @(negedge clk); vld[d] = 1'b1; dat[d] = b;
    while (!ok && t < 64) begin
      r = (d == 0) ? bus0.out_ready : bus1.out_ready;
      @(posedge clk);
      if (r) ok = 1;
      else begin @(negedge clk); t++; end
    end
    if (!ok) begin
      total++; bad++;
      $display("FAIL accept_timeout: byte %h on dut%0d never accepted", b, d);
    end
    if (gap) begin @(negedge clk); vld[d] = 1'b0; @(posedge clk); end
  endtask

  task automatic idle(input int d);
    @(negedge clk); vld[d] = 1'b0;
  endtask

  task automatic send_frame(input int d, input logic [7:0] fr[$], input bit gap);
`ifdef PROGRAM_LOADER_CHECKSUM_EN
    logic [7:0] x;
    x = 8'h00;
    foreach (fr[i]) if (i >= 2) x = x ^ fr[i];
`endif
    foreach (fr[i]) drive(d, fr[i], gap);
`ifdef PROGRAM_LOADER_CHECKSUM_EN
    drive(d, x, gap);
`endif
    idle(d);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    total++; if (hold0 !== 1'b1) begin bad++; $display("FAIL reset_hold: got %b want 1", hold0); end
    total++; if (hold1 !== 1'b1) begin bad++; $display("FAIL reset_hold1: got %b want 1", hold1); end
    total++; if ({busy0, done0, err0} !== 3'b000) begin bad++; $display("FAIL reset_status: got %b want 000", {busy0, done0, err0}); end
    total++; if ({bus0.out_ready, bus0.out_wr_en} !== 2'b00) begin bad++; $display("FAIL reset_ready_wr: got %b want 00", {bus0.out_ready, bus0.out_wr_en}); end
    total++; if (wc0 !== 16'd0) begin bad++; $display("FAIL reset_count: got %0d want 0", wc0); end
    rst = 1'b0;
  endtask

  task automatic test_basic();
    wq0.delete();
    pulse_start(0);
    total++; if ({busy0, hold0, bus0.out_ready} !== 3'b111) begin bad++; $display("FAIL start_status: got %b want 111", {busy0, hold0, bus0.out_ready}); end
    send_frame(0, '{8'h00, 8'h02, 8'h10, 8'h40, 8'h00, 8'h05, 8'h2A, 8'hBC, 8'h00, 8'h00}, 1'b0);
    repeat (3) @(negedge clk);
    total++; if (wq0.size() !== 2) begin bad++; $display("FAIL basic_nwrites: got %0d want 2", wq0.size()); end
    if (wq0.size() == 2) begin
      total++; if (wq0[0].a !== 8'd0 || wq0[0].d !== 32'h10400005) begin bad++; $display("FAIL basic_w0: got %h/%h want 00/10400005", wq0[0].a, wq0[0].d); end
      total++; if (wq0[1].a !== 8'd1 || wq0[1].d !== 32'h2ABC0000) begin bad++; $display("FAIL basic_w1: got %h/%h want 01/2abc0000", wq0[1].a, wq0[1].d); end
      total++; if (wq0[1].c - wq0[0].c !== 4) begin bad++; $display("FAIL basic_spacing: got %0d want 4", wq0[1].c - wq0[0].c); end
      total++; if (wq0[1].h !== 1'b1) begin bad++; $display("FAIL basic_hold_at_write: got %b want 1", wq0[1].h); end
      total++; if (done_cyc[0] !== wq0[1].c + 1) begin bad++; $display("FAIL basic_done_timing: got cycle %0d want %0d", done_cyc[0], wq0[1].c + 1); end
    end
    total++; if ({done0, hold0, busy0, err0} !== 4'b1000) begin bad++; $display("FAIL basic_final: got %b want 1000", {done0, hold0, busy0, err0}); end
    total++; if (wc0 !== 16'd2) begin bad++; $display("FAIL basic_count: got %0d want 2", wc0); end
    total++; if (bus0.out_ready !== 1'b0) begin bad++; $display("FAIL basic_ready_done: got %b want 0", bus0.out_ready); end
  endtask

  task automatic test_gaps();
    wq0.delete();
    pulse_start(0);
    total++; if ({done0, hold0, wc0} !== {2'b01, 16'd0}) begin bad++; $display("FAIL restart_clear: got done=%b hold=%b wc=%0d want 0/1/0", done0, hold0, wc0); end
    send_frame(0, '{8'h00, 8'h02, 8'h10, 8'h40, 8'h00, 8'h05, 8'h2A, 8'hBC, 8'h00, 8'h00}, 1'b1);
    repeat (3) @(negedge clk);
    total++; if (wq0.size() !== 2) begin bad++; $display("FAIL gaps_nwrites: got %0d want 2", wq0.size()); end
    if (wq0.size() == 2) begin
      total++; if (wq0[0].a !== 8'd0 || wq0[0].d !== 32'h10400005) begin bad++; $display("FAIL gaps_w0: got %h/%h want 00/10400005", wq0[0].a, wq0[0].d); end
      total++; if (wq0[1].a !== 8'd1 || wq0[1].d !== 32'h2ABC0000) begin bad++; $display("FAIL gaps_w1: got %h/%h want 01/2abc0000", wq0[1].a, wq0[1].d); end
    end
    total++; if ({done0, hold0, wc0} !== {2'b10, 16'd2}) begin bad++; $display("FAIL gaps_final: got done=%b hold=%b wc=%0d want 1/0/2", done0, hold0, wc0); end
  endtask

  task automatic test_zero_len();
    wq0.delete();
    pulse_start(0);
    send_frame(0, '{8'h00, 8'h00}, 1'b0);
    repeat (3) @(negedge clk);
    total++; if (wq0.size() !== 0) begin bad++; $display("FAIL zero_nwrites: got %0d want 0", wq0.size()); end
    total++; if ({done0, err0, hold0, wc0} !== {3'b100, 16'd0}) begin bad++; $display("FAIL zero_final: got done=%b err=%b hold=%b wc=%0d want 1/0/0/0", done0, err0, hold0, wc0); end
  endtask

  task automatic test_len_error();
    wq0.delete();
    pulse_start(0);
    drive(0, 8'h01, 1'b0);
    drive(0, 8'h01, 1'b0);
    idle(0);
    total++; if ({err0, hold0, busy0, bus0.out_ready} !== 4'b1100) begin bad++; $display("FAIL lenerr_state: got %b want 1100", {err0, hold0, busy0, bus0.out_ready}); end
    repeat (3) @(negedge clk);
    total++; if (wq0.size() !== 0) begin bad++; $display("FAIL lenerr_nwrites: got %0d want 0", wq0.size()); end
    pulse_start(0);
    total++; if ({err0, busy0} !== 2'b01) begin bad++; $display("FAIL lenerr_restart: got err=%b busy=%b want 0/1", err0, busy0); end
    send_frame(0, '{8'h00, 8'h01, 8'hDE, 8'hAD, 8'hBE, 8'hEF}, 1'b0);
    repeat (3) @(negedge clk);
    total++; if (wq0.size() !== 1) begin bad++; $display("FAIL recover_nwrites: got %0d want 1", wq0.size()); end
    if (wq0.size() == 1) begin
      total++; if (wq0[0].a !== 8'd0 || wq0[0].d !== 32'hDEADBEEF) begin bad++; $display("FAIL recover_w0: got %h/%h want 00/deadbeef", wq0[0].a, wq0[0].d); end
    end
    total++; if ({done0, hold0, wc0} !== {2'b10, 16'd1}) begin bad++; $display("FAIL recover_final: got done=%b hold=%b wc=%0d want 1/0/1", done0, hold0, wc0); end
  endtask

  task automatic test_wrap();
    wq1.delete();
    pulse_start(1);
    send_frame(1, '{8'h00, 8'h03, 8'h01, 8'h02, 8'h03, 8'h04, 8'hA0, 8'hB0, 8'hC0, 8'hD0,
                    8'h00, 8'h00, 8'hFF, 8'hFF}, 1'b0);
    repeat (3) @(negedge clk);
    total++; if (wq1.size() !== 3) begin bad++; $display("FAIL wrap_nwrites: got %0d want 3", wq1.size()); end
    if (wq1.size() == 3) begin
      total++; if (wq1[0].a !== 8'd254 || wq1[0].d !== 32'h01020304) begin bad++; $display("FAIL wrap_w0: got %0d/%h want 254/01020304", wq1[0].a, wq1[0].d); end
      total++; if (wq1[1].a !== 8'd255 || wq1[1].d !== 32'hA0B0C0D0) begin bad++; $display("FAIL wrap_w1: got %0d/%h want 255/a0b0c0d0", wq1[1].a, wq1[1].d); end
      total++; if (wq1[2].a !== 8'd0 || wq1[2].d !== 32'h0000FFFF) begin bad++; $display("FAIL wrap_w2: got %0d/%h want 0/0000ffff", wq1[2].a, wq1[2].d); end
    end
    total++; if ({done1, hold1, wc1} !== {2'b10, 16'd3}) begin bad++; $display("FAIL wrap_final: got done=%b hold=%b wc=%0d want 1/0/3", done1, hold1, wc1); end
  endtask

  task automatic test_reset_midload();
    wq0.delete();
    pulse_start(0);
    drive(0, 8'h00, 1'b0); drive(0, 8'h02, 1'b0);
    drive(0, 8'hCA, 1'b0); drive(0, 8'hFE, 1'b0); drive(0, 8'hF0, 1'b0); drive(0, 8'h0D, 1'b0);
    drive(0, 8'h11, 1'b0); drive(0, 8'h22, 1'b0);
    @(negedge clk); vld[0] = 1'b0; rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    repeat (3) @(negedge clk);
    total++; if (wq0.size() !== 1) begin bad++; $display("FAIL midrst_nwrites: got %0d want 1", wq0.size()); end
    if (wq0.size() == 1) begin
      total++; if (wq0[0].a !== 8'd0 || wq0[0].d !== 32'hCAFEF00D) begin bad++; $display("FAIL midrst_w0: got %h/%h want 00/cafef00d", wq0[0].a, wq0[0].d); end
    end
    total++; if ({busy0, hold0, done0, bus0.out_ready, wc0} !== {4'b0100, 16'd0}) begin bad++; $display("FAIL midrst_state: got busy=%b hold=%b done=%b rdy=%b wc=%0d want 0/1/0/0/0", busy0, hold0, done0, bus0.out_ready, wc0); end

    // Reset coinciding with the last byte of a word must suppress its write.
    wq0.delete();
    pulse_start(0);
    drive(0, 8'h00, 1'b0); drive(0, 8'h01, 1'b0);
    drive(0, 8'h55, 1'b0); drive(0, 8'h66, 1'b0); drive(0, 8'h77, 1'b0);
    @(negedge clk); dat[0] = 8'h88; rst = 1'b1;
    @(negedge clk); rst = 1'b0; vld[0] = 1'b0;
    repeat (3) @(negedge clk);
    total++; if (wq0.size() !== 0) begin bad++; $display("FAIL rst_pulse_suppress: got %0d writes want 0", wq0.size()); end
    total++; if ({busy0, hold0, wc0} !== {2'b01, 16'd0}) begin bad++; $display("FAIL rst_pulse_state: got busy=%b hold=%b wc=%0d want 0/1/0", busy0, hold0, wc0); end
  endtask

`ifdef PROGRAM_LOADER_CHECKSUM_EN
  task automatic test_checksum();
    wq0.delete();
    pulse_start(0);
    drive(0, 8'h00, 1'b0); drive(0, 8'h01, 1'b0);
    drive(0, 8'h11, 1'b0); drive(0, 8'h22, 1'b0); drive(0, 8'h33, 1'b0); drive(0, 8'h44, 1'b0);
    drive(0, 8'h44, 1'b0);
    idle(0);
    repeat (2) @(negedge clk);
    total++; if ({done0, err0, hold0} !== 3'b100) begin bad++; $display("FAIL csum_good: got done=%b err=%b hold=%b want 1/0/0", done0, err0, hold0); end
    total++; if (wq0.size() !== 1) begin bad++; $display("FAIL csum_good_nwrites: got %0d want 1", wq0.size()); end

    wq0.delete();
    pulse_start(0);
    drive(0, 8'h00, 1'b0); drive(0, 8'h01, 1'b0);
    drive(0, 8'h11, 1'b0); drive(0, 8'h22, 1'b0); drive(0, 8'h33, 1'b0); drive(0, 8'h44, 1'b0);
    drive(0, 8'h45, 1'b0);
    idle(0);
    repeat (2) @(negedge clk);
    total++; if ({done0, err0, hold0} !== 3'b011) begin bad++; $display("FAIL csum_bad: got done=%b err=%b hold=%b want 0/1/1", done0, err0, hold0); end
    total++; if (wq0.size() !== 1) begin bad++; $display("FAIL csum_bad_nwrites: got %0d want 1", wq0.size()); end
    if (wq0.size() == 1) begin
      total++; if (wq0[0].d !== 32'h11223344) begin bad++; $display("FAIL csum_bad_word: got %h want 11223344", wq0[0].d); end
    end
  endtask
`endif

  initial begin
    vld[0] = 1'b0; vld[1] = 1'b0;
    dat[0] = 8'h00; dat[1] = 8'h00;
    st[0] = 1'b0; st[1] = 1'b0;
    done_cyc[0] = -1; done_cyc[1] = -1;
    test_reset();
    test_basic();
    test_gaps();
    test_zero_len();
    test_len_error();
    test_wrap();
    test_reset_midload();
`ifdef PROGRAM_LOADER_CHECKSUM_EN
    test_checksum();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
